seq_divider4: RTL

Sequential unsigned restoring divider that time-multiplexes a single WIDTH-bit subtractor (A + ~B + 1, carry-out high = no borrow) across WIDTH shift-subtract iterations. It takes a dividend/divisor pair on a one-cycle start pulse and returns quotient and remainder after a fixed latency, with a busy/done handshake. It is the control block for the counter/arithmetic exercises and drives the subtractor datapath.

---
 rtl/seq_divider4_pkg.sv | 13 +
 rtl/seq_divider4_sub_unit.sv | 27 ++
 rtl/seq_divider4.sv | 110 +++++++++++
 3 files changed

// File: rtl/seq_divider4_pkg.sv
// seq_divider4 shared types and constants.
// FSM state encoding and default operand width.
package seq_divider4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/seq_divider4_sub_unit.sv
// Ripple-carry subtractor: a + ~b + 1.
// cout high means no borrow (a >= b).
module sub_unit
    import seq_divider4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             cout
);

    logic [WIDTH:0] c;
    logic [WIDTH-1:0] nb;

    assign c[0] = 1'b1;
    assign nb   = ~b;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign diff[i]  = a[i] ^ nb[i] ^ c[i];
        assign c[i + 1] = (a[i] & nb[i]) | (c[i] & (a[i] ^ nb[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/seq_divider4.sv
// Sequential restoring divider, one subtract per cycle.
// Busy/done handshake; results held until next accepted start.
module seq_divider4
    import seq_divider4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t state, state_nx;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt;
    logic             dz_r;

    logic [WIDTH-1:0] sub_a;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             succ;
    logic             accept;

    // Low WIDTH bits of the shifted partial remainder {R, Q msb}.
    assign sub_a = {r_r[WIDTH-2:0], q_r[WIDTH-1]};

    sub_unit #(.WIDTH(WIDTH)) u_sub (
        .a    (sub_a),
        .b    (dvs_r),
        .diff (diff),
        .cout (cout)
    );

    // Bit shifted out of R makes S >= 2^WIDTH > divisor.
    assign succ   = r_r[WIDTH-1] | cout;
    assign accept = start & (state != RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                if (start)
                    state_nx = (divisor == '0) ? DONE : RUN;
                else
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and shift-subtract datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r   <= '0;
            r_r   <= '0;
            dvs_r <= '0;
            cnt   <= '0;
            dz_r  <= 1'b0;
        end else if (accept) begin
            dvs_r <= divisor;
            cnt   <= CW'(WIDTH - 1);
            if (divisor == '0) begin
                q_r  <= '1;
                r_r  <= dividend;
                dz_r <= 1'b1;
            end else begin
                q_r  <= dividend;
                r_r  <= '0;
                dz_r <= 1'b0;
            end
        end else if (state == RUN) begin
            r_r <= succ ? diff : sub_a;
            q_r <= {q_r[WIDTH-2:0], succ};
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign quotient  = q_r;
    assign remainder = r_r;
    assign div_zero  = dz_r;

endmodule
